// File: rtl/div_result_bcd.sv
// Converts a divider's binary quotient/remainder to 3-digit BCD with shift-add-3 (double dabble),
// capturing operands on the falling edge of the divider's Busy.
module div_result_bcd #(
  parameter bit STICKY_VALID = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Busy_In,
  input  logic [7:0]  In_Q,
  input  logic [7:0]  In_R,
  output logic [11:0] Out_QBCD,
  output logic [11:0] Out_RBCD,
  output logic        Valid,
  output logic        Conv_Busy,
  output logic        Overrun
);

  typedef enum logic {StIdle, StConv} state_e;

  state_e      state_q, state_d;
  logic        busy_prev_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  q_sh_q, q_sh_d, r_sh_q, r_sh_d;
  logic [11:0] q_acc_q, q_acc_d, r_acc_q, r_acc_d;
  logic [11:0] q_out_q, q_out_d, r_out_q, r_out_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;

  logic        capture;
  logic [11:0] q_adj, r_adj, q_acc_nxt, r_acc_nxt;

  function automatic logic [11:0] bcd_adj(input logic [11:0] a);
    logic [11:0] res;
    res = a;
    for (int i = 0; i < 3; i++) begin
      if (a[4*i +: 4] >= 4'd5) res[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  assign capture   = busy_prev_q & ~Busy_In;
  assign q_adj     = bcd_adj(q_acc_q);
  assign r_adj     = bcd_adj(r_acc_q);
  assign q_acc_nxt = {q_adj[10:0], q_sh_q[7]};
  assign r_acc_nxt = {r_adj[10:0], r_sh_q[7]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_sh_d    = q_sh_q;
    r_sh_d    = r_sh_q;
    q_acc_d   = q_acc_q;
    r_acc_d   = r_acc_q;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    // Non-sticky Valid falls back to 0 one cycle after completion
    valid_d   = STICKY_VALID ? valid_q : 1'b0;
    overrun_d = capture && (state_q == StConv);
    case (state_q)
      StIdle: begin
        if (capture) begin
          q_sh_d  = In_Q;
          r_sh_d  = In_R;
          q_acc_d = '0;
          r_acc_d = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = StConv;
        end
      end
      StConv: begin
        q_acc_d = q_acc_nxt;
        r_acc_d = r_acc_nxt;
        q_sh_d  = {q_sh_q[6:0], 1'b0};
        r_sh_d  = {r_sh_q[6:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          q_out_d = q_acc_nxt;
          r_out_d = r_acc_nxt;
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      busy_prev_q <= 1'b0;
      cnt_q       <= '0;
      q_sh_q      <= '0;
      r_sh_q      <= '0;
      q_acc_q     <= '0;
      r_acc_q     <= '0;
      q_out_q     <= '0;
      r_out_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_prev_q <= Busy_In;
      cnt_q       <= cnt_d;
      q_sh_q      <= q_sh_d;
      r_sh_q      <= r_sh_d;
      q_acc_q     <= q_acc_d;
      r_acc_q     <= r_acc_d;
      q_out_q     <= q_out_d;
      r_out_q     <= r_out_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign Out_QBCD  = q_out_q;
  assign Out_RBCD  = r_out_q;
  assign Valid     = valid_q;
  assign Conv_Busy = (state_q == StConv);
  assign Overrun   = overrun_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: sticky and pulsed-Valid instances share one stimulus stream.
module tb_div_result_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Busy_In = 1'b0;
  logic [7:0]  In_Q = '0;
  logic [7:0]  In_R = '0;

  logic [11:0] qs, rs, qn, rn;
  logic        vs, cbs, ovs, vn, cbn, ovn;

  int errors = 0;
  int checks = 0;
  logic [11:0] prev_q = '0;
  logic [11:0] prev_r = '0;

  always #5 clk = ~clk;

  div_result_bcd #(.STICKY_VALID(1'b1)) dut_s (
    .clk(clk), .rst(rst), .Busy_In(Busy_In), .In_Q(In_Q), .In_R(In_R),
    .Out_QBCD(qs), .Out_RBCD(rs), .Valid(vs), .Conv_Busy(cbs), .Overrun(ovs)
  );

  div_result_bcd #(.STICKY_VALID(1'b0)) dut_n (
    .clk(clk), .rst(rst), .Busy_In(Busy_In), .In_Q(In_Q), .In_R(In_R),
    .Out_QBCD(qn), .Out_RBCD(rn), .Valid(vn), .Conv_Busy(cbn), .Overrun(ovn)
  );

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Busy_In 1 for one cycle then 0; returns just after the capture edge k.
  task automatic start(input logic [7:0] q, input logic [7:0] r);
    Busy_In = 1'b1;
    In_Q = q;
    In_R = r;
    tick();
    checks++;
    if (cbs !== 1'b0) begin
      errors++;
      $display("FAIL busy_rise_no_effect: Conv_Busy=%b required 0", cbs);
    end
    Busy_In = 1'b0;
    tick();
    In_Q = ~q;
    In_R = ~r;
  endtask

  task automatic run_conv(input logic [7:0] q, input logic [7:0] r,
                          input logic [11:0] eq, input logic [11:0] er);
    start(q, r);
    checks++;
    if (cbs !== 1'b1 || vs !== 1'b0) begin
      errors++;
      $display("FAIL capture: Conv_Busy=%b Valid=%b required 1 0", cbs, vs);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (cbs !== 1'b1 || qs !== prev_q || rs !== prev_r) begin
        errors++;
        $display("FAIL hold_in_conv cyc%0d: busy=%b q=%h r=%h required 1 %h %h",
                 i, cbs, qs, rs, prev_q, prev_r);
      end
    end
    tick();
    checks++;
    if (cbs !== 1'b0 || vs !== 1'b1 || qs !== eq || rs !== er || ovs !== 1'b0) begin
      errors++;
      $display("FAIL result q=%0d r=%0d: busy=%b valid=%b Q=%h R=%h ov=%b required 0 1 %h %h 0",
               q, r, cbs, vs, qs, rs, ovs, eq, er);
    end
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (qs !== 12'h000 || rs !== 12'h000 || vs !== 1'b0 || cbs !== 1'b0 || ovs !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%h r=%h v=%b cb=%b ov=%b required all 0", qs, rs, vs, cbs, ovs);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_conv(8'd255, 8'd0, 12'h255, 12'h000);
    run_conv(8'd100, 8'd7, 12'h100, 12'h007);
    run_conv(8'd9, 8'd99, 12'h009, 12'h099);
    tick();
    checks++;
    if (vs !== 1'b1 || qs !== 12'h009 || rs !== 12'h099) begin
      errors++;
      $display("FAIL sticky_hold: valid=%b q=%h r=%h required 1 009 099", vs, qs, rs);
    end
  endtask

  task automatic test_overrun();
    start(8'd200, 8'd13);
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (ovs !== (e == 3) || cbs !== (e < 8)) begin
        errors++;
        $display("FAIL overrun cyc%0d: ov=%b busy=%b required %b %b", e, ovs, cbs, e == 3, e < 8);
      end
      if (e == 1) begin
        Busy_In = 1'b1;
        In_Q = 8'd1;
        In_R = 8'd2;
      end
      if (e == 2) Busy_In = 1'b0;
    end
    checks++;
    if (vs !== 1'b1 || qs !== 12'h200 || rs !== 12'h013) begin
      errors++;
      $display("FAIL overrun_result: valid=%b q=%h r=%h required 1 200 013", vs, qs, rs);
    end
    prev_q = 12'h200;
    prev_r = 12'h013;
  endtask

  task automatic test_overrun_at_completion();
    start(8'd7, 8'd8);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) Busy_In = 1'b1;
      if (e == 7) Busy_In = 1'b0;
    end
    checks++;
    if (vs !== 1'b1 || qs !== 12'h007 || rs !== 12'h008 || ovs !== 1'b1 || cbs !== 1'b0) begin
      errors++;
      $display("FAIL completion_overrun: v=%b q=%h r=%h ov=%b cb=%b required 1 007 008 1 0",
               vs, qs, rs, ovs, cbs);
    end
    tick();
    checks++;
    if (ovs !== 1'b0 || cbs !== 1'b0 || vs !== 1'b1) begin
      errors++;
      $display("FAIL completion_overrun_after: ov=%b cb=%b v=%b required 0 0 1", ovs, cbs, vs);
    end
    prev_q = 12'h007;
    prev_r = 12'h008;
  endtask

  task automatic test_reset_in_conv();
    start(8'd123, 8'd45);
    for (int e = 1; e <= 4; e++) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (qs !== 12'h000 || rs !== 12'h000 || vs !== 1'b0 || cbs !== 1'b0 || ovs !== 1'b0 ||
        qn !== 12'h000 || cbn !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: q=%h r=%h v=%b cb=%b ov=%b qn=%h required all 0",
               qs, rs, vs, cbs, ovs, qn);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (vs !== 1'b0 || cbs !== 1'b0 || qs !== 12'h000) begin
        errors++;
        $display("FAIL post_reset_idle cyc%0d: v=%b cb=%b q=%h required 0 0 000", i, vs, cbs, qs);
      end
    end
    prev_q = '0;
    prev_r = '0;
  endtask

  task automatic test_pulse_valid();
    run_conv(8'd42, 8'd5, 12'h042, 12'h005);
    checks++;
    if (vn !== 1'b1 || qn !== 12'h042 || rn !== 12'h005) begin
      errors++;
      $display("FAIL pulse_valid_rise: v=%b q=%h r=%h required 1 042 005", vn, qn, rn);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (vn !== 1'b0 || qn !== 12'h042 || rn !== 12'h005 || vs !== 1'b1) begin
        errors++;
        $display("FAIL pulse_valid_after cyc%0d: vn=%b q=%h r=%h vs=%b required 0 042 005 1",
                 i, vn, qn, rn, vs);
      end
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), 8'(255 - v), to_bcd(v), to_bcd(255 - v));
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (qs[4*d +: 4] > 4'd9 || rs[4*d +: 4] > 4'd9 || qs[11:8] > 4'd2 || rs[11:8] > 4'd2) begin
          errors++;
          $display("FAIL digit_range v=%0d d=%0d: q=%h r=%h required digits <= 9", v, d, qs, rs);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overrun();
    test_overrun_at_completion();
    test_reset_in_conv();
    test_pulse_valid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
